// File: rtl/xtea_core.sv
// XTEA block cipher engine: one 64-bit block per transaction, encrypt or decrypt chosen per block.
// Latency ROUNDS/UNROLL clocks of RUN after accept; in_ready low until the result is taken (out_valid held under backpressure).
module xtea_core #(
    parameter int unsigned ROUNDS = 32,
    parameter int unsigned UNROLL = 1,
    parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [31:0]  data_in1,
    input  logic [31:0]  data_in2,
    input  logic [127:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  data_out1,
    output logic [31:0]  data_out2,
    output logic         busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Decrypt starts from the sum the encrypt pass would end on.
    localparam logic [31:0] SUM_DEC = DELTA * ROUNDS;
    localparam logic [7:0]  LAST    = 8'(ROUNDS);
    localparam logic [7:0]  STEP    = 8'(UNROLL);

    if (ROUNDS < 1 || ROUNDS > 255 || !(UNROLL == 1 || UNROLL == 2 || UNROLL == 4) ||
        (ROUNDS % UNROLL) != 0) begin : g_bad_params
        $error("xtea_core: ROUNDS must be 1..255 and a multiple of UNROLL (1, 2 or 4)");
    end

    logic [1:0]   state;
    logic [31:0]  v0;
    logic [31:0]  v1;
    logic [31:0]  sum;
    logic [127:0] key_q;
    logic         mode_q;
    logic [7:0]   cnt;

    logic [31:0]  r_v0;
    logic [31:0]  r_v1;
    logic [31:0]  r_sum;
    logic [7:0]   cnt_next;

    function automatic logic [31:0] kword(input logic [127:0] k, input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = k[127:96];
            2'd1:    w = k[95:64];
            2'd2:    w = k[63:32];
            default: w = k[31:0];
        endcase
        return w;
    endfunction

    function automatic logic [31:0] mix(input logic [31:0] v);
        return ((v << 4) ^ (v >> 5)) + v;
    endfunction

    // UNROLL full cycles chained combinationally per clock.
    always_comb begin
        r_v0  = v0;
        r_v1  = v1;
        r_sum = sum;
        for (int unsigned i = 0; i < UNROLL; i++) begin
            if (!mode_q) begin
                r_v0  = r_v0 + (mix(r_v1) ^ (r_sum + kword(key_q, r_sum[1:0])));
                r_sum = r_sum + DELTA;
                r_v1  = r_v1 + (mix(r_v0) ^ (r_sum + kword(key_q, r_sum[12:11])));
            end else begin
                r_v1  = r_v1 - (mix(r_v0) ^ (r_sum + kword(key_q, r_sum[12:11])));
                r_sum = r_sum - DELTA;
                r_v0  = r_v0 - (mix(r_v1) ^ (r_sum + kword(key_q, r_sum[1:0])));
            end
        end
    end

    assign cnt_next = cnt + STEP;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            v0        <= '0;
            v1        <= '0;
            sum       <= '0;
            key_q     <= '0;
            mode_q    <= 1'b0;
            cnt       <= '0;
            data_out1 <= '0;
            data_out2 <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        v0     <= data_in1;
                        v1     <= data_in2;
                        key_q  <= key_in;
                        mode_q <= mode;
                        sum    <= mode ? SUM_DEC : 32'd0;
                        cnt    <= '0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    v0  <= r_v0;
                    v1  <= r_v1;
                    sum <= r_sum;
                    cnt <= cnt_next;
                    if (cnt_next == LAST) begin
                        data_out1 <= r_v0;
                        data_out2 <= r_v1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_RUN) || (state == S_DONE);

endmodule

// File: tb/tb_xtea_core.sv
// Directed bench for xtea_core: default, UNROLL=2, UNROLL=4 and ROUNDS=8 instances share stimulus buses.
module tb_xtea_core;

    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [63:0]  PT  = 64'h41424344_45464748;
    localparam logic [63:0]  CT  = 64'h497df3d0_72612cb5;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [3:0]   out_valid;
    logic [3:0]   busy;
    logic         mode;
    logic         out_ready;
    logic [31:0]  data_in1;
    logic [31:0]  data_in2;
    logic [127:0] key_in;
    logic [31:0]  dout1 [4];
    logic [31:0]  dout2 [4];

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    xtea_core u_dut (.clock(clock), .reset_n(reset_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .mode(mode), .data_in1(data_in1), .data_in2(data_in2), .key_in(key_in),
        .out_valid(out_valid[0]), .out_ready(out_ready), .data_out1(dout1[0]), .data_out2(dout2[0]),
        .busy(busy[0]));
    xtea_core #(.UNROLL(2)) u_u2 (.clock(clock), .reset_n(reset_n), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .mode(mode), .data_in1(data_in1), .data_in2(data_in2), .key_in(key_in),
        .out_valid(out_valid[1]), .out_ready(out_ready), .data_out1(dout1[1]), .data_out2(dout2[1]),
        .busy(busy[1]));
    xtea_core #(.UNROLL(4)) u_u4 (.clock(clock), .reset_n(reset_n), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .mode(mode), .data_in1(data_in1), .data_in2(data_in2), .key_in(key_in),
        .out_valid(out_valid[2]), .out_ready(out_ready), .data_out1(dout1[2]), .data_out2(dout2[2]),
        .busy(busy[2]));
    xtea_core #(.ROUNDS(8)) u_r8 (.clock(clock), .reset_n(reset_n), .in_valid(in_valid[3]),
        .in_ready(in_ready[3]), .mode(mode), .data_in1(data_in1), .data_in2(data_in2), .key_in(key_in),
        .out_valid(out_valid[3]), .out_ready(out_ready), .data_out1(dout1[3]), .data_out2(dout2[3]),
        .busy(busy[3]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Straight XTEA reference, used for the reduced-round instance.
    function automatic logic [63:0] ref_xtea(input logic m, input int rounds, input logic [127:0] k,
                                             input logic [63:0] blk);
        logic [31:0] kk [4];
        logic [31:0] y, z, s;
        kk[0] = k[127:96]; kk[1] = k[95:64]; kk[2] = k[63:32]; kk[3] = k[31:0];
        y = blk[63:32];
        z = blk[31:0];
        if (!m) begin
            s = 32'd0;
            for (int r = 0; r < rounds; r++) begin
                y = y + ((((z << 4) ^ (z >> 5)) + z) ^ (s + kk[s & 32'd3]));
                s = s + 32'h9E3779B9;
                z = z + ((((y << 4) ^ (y >> 5)) + y) ^ (s + kk[(s >> 11) & 32'd3]));
            end
        end else begin
            s = 32'h9E3779B9 * rounds;
            for (int r = 0; r < rounds; r++) begin
                z = z - ((((y << 4) ^ (y >> 5)) + y) ^ (s + kk[(s >> 11) & 32'd3]));
                s = s - 32'h9E3779B9;
                y = y - ((((z << 4) ^ (z >> 5)) + z) ^ (s + kk[s & 32'd3]));
            end
        end
        return {y, z};
    endfunction

    // Presents one block and returns #1 after the accept edge.
    task automatic start(input int idx, input logic m, input logic [63:0] blk, input logic [127:0] k);
        @(negedge clock);
        mode          = m;
        data_in1      = blk[63:32];
        data_in2      = blk[31:0];
        key_in        = k;
        in_valid[idx] = 1'b1;
        check("in_ready_before_accept", 64'(in_ready[idx]), 64'd1);
        @(posedge clock);
        #1;
        in_valid[idx] = 1'b0;
        check("busy_after_accept", 64'(busy[idx]), 64'd1);
    endtask

    // Latency counts the accept cycle as cycle 1 up to the first cycle showing out_valid.
    task automatic wait_done(input int idx, input bit scramble, output int lat, output logic [63:0] res);
        lat = 1;
        while (!out_valid[idx] && lat < 400) begin
            if (scramble) begin
                data_in1 = $urandom;
                data_in2 = $urandom;
                key_in   = {$urandom, $urandom, $urandom, $urandom};
                mode     = ~mode;
            end
            @(posedge clock);
            #1;
            lat++;
        end
        res = {dout1[idx], dout2[idx]};
    endtask

    // One handshake edge with out_ready high; result must stay on data_out afterwards.
    task automatic drain(input int idx, input logic [63:0] res);
        @(posedge clock);
        #1;
        check("out_valid_after_hs", 64'(out_valid[idx]), 64'd0);
        check("in_ready_after_hs", 64'(in_ready[idx]), 64'd1);
        check("dout_retained", {dout1[idx], dout2[idx]}, res);
    endtask

    initial begin
        int          lat;
        logic [63:0] res;
        logic [63:0] held;
        logic [63:0] rt_pt;
        logic [63:0] rt_ct;
        logic [127:0] rt_key;

        reset_n   = 1'b0;
        in_valid  = '0;
        out_ready = 1'b1;
        mode      = 1'b0;
        data_in1  = '0;
        data_in2  = '0;
        key_in    = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_in_ready", 64'(in_ready[0]), 64'd1);
        check("rst_out_valid", 64'(out_valid[0]), 64'd0);
        check("rst_busy", 64'(busy[0]), 64'd0);
        check("rst_dout", {dout1[0], dout2[0]}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Known-answer vectors at each unroll factor.
        for (int i = 0; i < 3; i++) begin
            int exp_lat;
            exp_lat = (i == 0) ? 33 : (i == 1) ? 17 : 9;
            start(i, 1'b0, PT, KEY);
            wait_done(i, 1'b0, lat, res);
            check("enc_latency", 64'(lat), 64'(exp_lat));
            check("enc_result", res, CT);
            drain(i, CT);
            start(i, 1'b1, CT, KEY);
            wait_done(i, 1'b0, lat, res);
            check("dec_latency", 64'(lat), 64'(exp_lat));
            check("dec_result", res, PT);
            drain(i, PT);
        end

        // Round trip at ROUNDS=8 with random key and data.
        rt_key = {$urandom, $urandom, $urandom, $urandom};
        rt_pt  = {$urandom, $urandom};
        start(3, 1'b0, rt_pt, rt_key);
        wait_done(3, 1'b0, lat, rt_ct);
        check("r8_latency", 64'(lat), 64'd9);
        check("r8_enc_ref", rt_ct, ref_xtea(1'b0, 8, rt_key, rt_pt));
        drain(3, rt_ct);
        start(3, 1'b1, rt_ct, rt_key);
        check("r8_dec_sum_init", 64'(u_r8.sum), 64'hF1BBCDC8);
        wait_done(3, 1'b0, lat, res);
        check("r8_roundtrip", res, rt_pt);
        drain(3, rt_pt);

        // Inputs change every cycle after accept.
        start(0, 1'b0, PT, KEY);
        wait_done(0, 1'b1, lat, res);
        check("iso_latency", 64'(lat), 64'd33);
        check("iso_result", res, CT);
        drain(0, CT);

        // Backpressure with a second block waiting.
        @(negedge clock);
        out_ready = 1'b0;
        start(0, 1'b0, PT, KEY);
        wait_done(0, 1'b0, lat, held);
        check("bp_first_result", held, CT);
        mode        = 1'b1;
        data_in1    = CT[63:32];
        data_in2    = CT[31:0];
        key_in      = KEY;
        in_valid[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clock);
            #1;
            check("bp_out_valid_held", 64'(out_valid[0]), 64'd1);
            check("bp_in_ready_low", 64'(in_ready[0]), 64'd0);
            check("bp_dout_stable", {dout1[0], dout2[0]}, held);
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        check("bp_release_in_ready", 64'(in_ready[0]), 64'd1);
        check("bp_release_out_valid", 64'(out_valid[0]), 64'd0);
        @(posedge clock);
        #1;
        in_valid[0] = 1'b0;
        check("bp_second_accepted", 64'(busy[0]), 64'd1);
        wait_done(0, 1'b0, lat, res);
        check("bp_second_latency", 64'(lat), 64'd33);
        check("bp_second_result", res, PT);
        drain(0, PT);

        // Reset in the middle of RUN.
        start(0, 1'b0, PT, KEY);
        repeat (14) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_in_ready", 64'(in_ready[0]), 64'd1);
        check("midrst_out_valid", 64'(out_valid[0]), 64'd0);
        check("midrst_busy", 64'(busy[0]), 64'd0);
        check("midrst_dout", {dout1[0], dout2[0]}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        start(0, 1'b1, CT, KEY);
        wait_done(0, 1'b0, lat, res);
        check("post_rst_latency", 64'(lat), 64'd33);
        check("post_rst_result", res, PT);
        drain(0, PT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xtea_core.md
Name: xtea_core

Overview:
- Parameterised XTEA block-cipher engine; encrypts or decrypts one 64-bit block per transaction, selected per block by a mode input.
- Successor to the fixed 32-round decrypt-only engine. Adds run-time encrypt/decrypt selection, configurable round count, configurable rounds-per-clock unrolling, and valid/ready handshakes with backpressure on both sides.
- Sits between the data-path block buffer and the output packer; the key comes from the key register bank.

Parameters:
- ROUNDS, 32, number of XTEA cycles (each cycle is both half-rounds); legal range 1..255.
- UNROLL, 1, XTEA cycles computed per clock; legal values 1, 2, 4; ROUNDS must be a multiple of UNROLL (elaboration error otherwise).
- DELTA, 32'h9E3779B9, key-schedule constant.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input block valid.
- in_ready  out  1  engine can accept a block.
- mode  in  1  0 = encrypt, 1 = decrypt; sampled at accept.
- data_in1  in  32  word v0 of input block.
- data_in2  in  32  word v1 of input block.
- key_in  in  128  key; k[0]=key_in[127:96], k[1]=[95:64], k[2]=[63:32], k[3]=[31:0]; sampled at accept.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- data_out1  out  32  result word v0.
- data_out2  out  32  result word v1.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; in_ready = 1; out_valid = 0; busy = 0.
  - data_out1 = data_out2 = 0; internal v0, v1, sum, key, mode and round counter all 0.
- Reset asserted mid-operation aborts the block immediately; no partial result appears.
- States:
  - IDLE: in_ready = 1. On in_valid & in_ready, latch data_in1/2 into v0/v1 and latch key_in and mode. Set sum = 0 for encrypt, or (DELTA*ROUNDS) mod 2^32 for decrypt (a constant; 0xC6EF3720 at the defaults). Clear the round counter. Go to RUN.
  - RUN: each clock performs UNROLL XTEA cycles combinationally chained, then adds UNROLL to the counter. When counter+UNROLL == ROUNDS, load data_out1/2 from the updated v0/v1 and go to DONE.
  - DONE: out_valid = 1; data_out held stable. On out_ready, go to IDLE (out_valid low next cycle).
- Encrypt cycle, all arithmetic mod 2^32, shifts logical:
  - v0 += (((v1<<4)^(v1>>5))+v1) ^ (sum + k[sum&3]);
  - sum += DELTA;
  - v1 += (((v0<<4)^(v0>>5))+v0) ^ (sum + k[(sum>>11)&3]).
- Decrypt cycle:
  - v1 -= (((v0<<4)^(v0>>5))+v0) ^ (sum + k[(sum>>11)&3]);
  - sum -= DELTA;
  - v0 -= (((v1<<4)^(v1>>5))+v1) ^ (sum + k[sum&3]).
- Latency: accept edge to out_valid high = ROUNDS/UNROLL + 1 clocks (33 at the defaults).
- No input is accepted in RUN or DONE (in_ready = 0). Changes on data_in, key_in or mode after accept have no effect.
- Backpressure: out_valid may be held any number of cycles; data_out stays unchanged. A new block can be accepted at the earliest on the cycle after the out_ready handshake, so there is one idle bubble between blocks.
- data_out1/2 retain the last result after the handshake until the next block completes.
- Sum and counter wrap naturally at their widths. The counter is 8 bits and cannot overflow for legal ROUNDS.

Test Plan:
- Encrypt vector: defaults, key 00010203_04050607_08090a0b_0c0d0e0f, data 41424344/45464748, mode=0, out_ready=1 -> out_valid exactly 33 clocks after accept, data_out 497df3d0/72612cb5.
- Decrypt vector: same key, data 497df3d0/72612cb5, mode=1 -> data_out 41424344/45464748. Repeat with UNROLL=2 and UNROLL=4 -> identical results, latency 17 and 9 clocks.
- Round trip: ROUNDS=8, random key and data; encrypt, then decrypt the result -> original data recovered. Sum at decrypt start must equal 0x9E3779B9*8 mod 2^32 = 0xF1BBCDC8.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_valid and data_out stable, in_ready=0 with in_valid=1. Release out_ready -> in_ready=1 the next cycle; a second block is accepted and completes correctly.
- Input isolation: after accept, toggle data_in, key_in and mode every cycle -> result still matches the vector latched at accept.
- Reset mid-run: drop reset_n at cycle 15 of RUN -> outputs 0, in_ready=1, out_valid=0 immediately. A new block afterwards completes with the correct result.
